// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, FSM states and datapath select encodings for the multi-cycle controller
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_IALU, C_LUI, C_LOAD, C_STORE,
      C_BRANCH, C_JAL, C_JALR, C_AUIPC, C_ILLEGAL
   } opclass_t;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_IMM    = 2'b01;
   localparam logic [1:0] PC_ALU    = 2'b10;

   localparam logic [1:0] WB_ALU    = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_PC4    = 2'b10;

   localparam logic [1:0] SRCA_RS1  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   // Control-flow opcodes collapse to C_ILLEGAL when jumps are not built in
   function automatic opclass_t decode_opcode(input logic [6:0] op, input logic jumps);
      case (op)
         OP_R:      return C_R;
         OP_IALU:   return C_IALU;
         OP_LUI:    return C_LUI;
         OP_LOAD:   return C_LOAD;
         OP_STORE:  return C_STORE;
         OP_BRANCH: return jumps ? C_BRANCH : C_ILLEGAL;
         OP_JAL:    return jumps ? C_JAL    : C_ILLEGAL;
         OP_JALR:   return jumps ? C_JALR   : C_ILLEGAL;
         OP_AUIPC:  return jumps ? C_AUIPC  : C_ILLEGAL;
         default:   return C_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait counter that flags a stalled memory access
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ready,
   output logic expired
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count;

   // Count wait cycles of the current access; restart whenever the access ends or the state is left
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (!active || ready)
         count <= '0;
      else if (count != LIMIT)
         count <= count + CW'(1);
   end

   // The cycle whose increment would reach the limit is the last one; a ready in that cycle still wins
   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         assign expired = active && !ready && (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with stalling memory handshake and sticky traps
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int ALUOP_W      = 2,
   parameter bit ENABLE_JUMPS = 1'b1,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode,
   input  logic               branch_taken,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic [1:0]         wb_sel,
   output logic [1:0]         alu_src_a,
   output logic               alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal_instr,
   output logic               bus_error
);

   state_t   state, state_nxt;
   opclass_t cls_q, cls_dec;
   logic     illegal_q, bus_error_q;
   logic     tmr_expired;
   logic [1:0] alu_op_cls;

   assign cls_dec = decode_opcode(opcode, ENABLE_JUMPS);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  ((state == S_FETCH) || (state == S_MEM)),
      .ready   (mem_ready),
      .expired (tmr_expired)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Latch the opcode class in DECODE and record sticky trap causes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_q       <= C_ILLEGAL;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         if (state == S_DECODE) cls_q <= cls_dec;
         if ((state == S_DECODE) && (cls_dec == C_ILLEGAL)) illegal_q <= 1'b1;
         if (tmr_expired) bus_error_q <= 1'b1;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
                   else if (tmr_expired) state_nxt = S_TRAP;
         S_DECODE: state_nxt = (cls_dec == C_ILLEGAL) ? S_TRAP : S_EXEC;
         S_EXEC:   case (cls_q)
                      C_LOAD, C_STORE:          state_nxt = S_MEM;
                      C_BRANCH, C_JAL, C_JALR:  state_nxt = S_FETCH;
                      default:                  state_nxt = S_WB;
                   endcase
         S_MEM:    if (mem_ready) state_nxt = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                   else if (tmr_expired) state_nxt = S_TRAP;
         S_WB:     state_nxt = S_FETCH;
         S_TRAP:   state_nxt = S_TRAP;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath controls from state and latched class; branch and store-ready terms are Mealy
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      reg_write  = 1'b0;
      wb_sel     = WB_ALU;
      alu_src_a  = SRCA_RS1;
      alu_src_b  = 1'b0;
      alu_op_cls = ALU_ADD;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
         end
         S_EXEC: begin
            case (cls_q)
               C_R:    alu_op_cls = ALU_FUNCT;
               C_IALU: begin alu_src_b = 1'b1; alu_op_cls = ALU_FUNCT; end
               C_LUI:  begin alu_src_a = SRCA_ZERO; alu_src_b = 1'b1; end
               C_AUIPC: begin alu_src_a = SRCA_PC; alu_src_b = 1'b1; end
               C_LOAD, C_STORE: alu_src_b = 1'b1;
               C_BRANCH: begin
                  alu_op_cls = ALU_BRANCH;
                  pc_write   = 1'b1;
                  pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
               end
               C_JAL: begin
                  reg_write = 1'b1;
                  wb_sel    = WB_PC4;
                  pc_write  = 1'b1;
                  pc_src    = PC_IMM;
               end
               C_JALR: begin
                  alu_src_b = 1'b1;
                  reg_write = 1'b1;
                  wb_sel    = WB_PC4;
                  pc_write  = 1'b1;
                  pc_src    = PC_ALU;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = (cls_q == C_STORE);
            alu_src_b = 1'b1;
            pc_write  = (cls_q == C_STORE) && mem_ready;
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            wb_sel    = (cls_q == C_LOAD) ? WB_MEM : WB_ALU;
         end
         default: ;
      endcase
   end

   assign alu_op        = ALUOP_W'(alu_op_cls);
   assign illegal_instr = illegal_q;
   assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
   import riscv_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, branch_taken, mem_ready;
   logic [6:0] opcode;
   logic       mem_req, mem_we, ir_write, pc_write, reg_write, alu_src_b, illegal_instr, bus_error;
   logic [1:0] pc_src, wb_sel, alu_src_a, alu_op;

   logic       rst_n2, mem_ready2;
   logic [6:0] opcode2;
   logic       mem_req2, mem_we2, ir_write2, pc_write2, reg_write2, alu_src_b2, illegal_instr2, bus_error2;
   logic [1:0] pc_src2, wb_sel2, alu_src_a2, alu_op2;

   int checks = 0;
   int errors = 0;

   // Field order: req we ir pcw pcs[2] rw wbs[2] a[2] b op[2] ill be
   wire [15:0] obs  = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel,
                       alu_src_a, alu_src_b, alu_op, illegal_instr, bus_error};
   wire [15:0] obs2 = {mem_req2, mem_we2, ir_write2, pc_write2, pc_src2, reg_write2, wb_sel2,
                       alu_src_a2, alu_src_b2, alu_op2, illegal_instr2, bus_error2};

   localparam logic [15:0] ZERO     = 16'b0_0_0_0_00_0_00_00_0_00_0_0;
   localparam logic [15:0] F_WAIT   = 16'b1_0_0_0_00_0_00_00_0_00_0_0;
   localparam logic [15:0] F_RDY    = 16'b1_0_1_0_00_0_00_00_0_00_0_0;
   localparam logic [15:0] X_R      = 16'b0_0_0_0_00_0_00_00_0_10_0_0;
   localparam logic [15:0] X_IALU   = 16'b0_0_0_0_00_0_00_00_1_10_0_0;
   localparam logic [15:0] X_LUI    = 16'b0_0_0_0_00_0_00_10_1_00_0_0;
   localparam logic [15:0] X_AUIPC  = 16'b0_0_0_0_00_0_00_01_1_00_0_0;
   localparam logic [15:0] X_LDST   = 16'b0_0_0_0_00_0_00_00_1_00_0_0;
   localparam logic [15:0] X_BR_T   = 16'b0_0_0_1_01_0_00_00_0_01_0_0;
   localparam logic [15:0] X_BR_N   = 16'b0_0_0_1_00_0_00_00_0_01_0_0;
   localparam logic [15:0] X_JAL    = 16'b0_0_0_1_01_1_10_00_0_00_0_0;
   localparam logic [15:0] X_JALR   = 16'b0_0_0_1_10_1_10_00_1_00_0_0;
   localparam logic [15:0] M_LOAD   = 16'b1_0_0_0_00_0_00_00_1_00_0_0;
   localparam logic [15:0] M_ST_W   = 16'b1_1_0_0_00_0_00_00_1_00_0_0;
   localparam logic [15:0] M_ST_R   = 16'b1_1_0_1_00_0_00_00_1_00_0_0;
   localparam logic [15:0] WB_A     = 16'b0_0_0_1_00_1_00_00_0_00_0_0;
   localparam logic [15:0] WB_L     = 16'b0_0_0_1_00_1_01_00_0_00_0_0;
   localparam logic [15:0] T_BUS    = 16'b0_0_0_0_00_0_00_00_0_00_0_1;
   localparam logic [15:0] T_ILL    = 16'b0_0_0_0_00_0_00_00_0_00_1_0;

   multicycle_controller #(.ALUOP_W(2), .ENABLE_JUMPS(1'b1), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .illegal_instr(illegal_instr), .bus_error(bus_error)
   );

   multicycle_controller #(.ALUOP_W(2), .ENABLE_JUMPS(1'b0), .MEM_TIMEOUT(15)) dut_nj (
      .clk(clk), .rst_n(rst_n2), .opcode(opcode2), .branch_taken(1'b0), .mem_ready(mem_ready2),
      .mem_req(mem_req2), .mem_we(mem_we2), .ir_write(ir_write2), .pc_write(pc_write2), .pc_src(pc_src2),
      .reg_write(reg_write2), .wb_sel(wb_sel2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
      .alu_op(alu_op2), .illegal_instr(illegal_instr2), .bus_error(bus_error2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] exp, input bit second = 1'b0);
      logic [15:0] o;
      #1;
      o = second ? obs2 : obs;
      checks++;
      assert (o === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, o, exp);
      end
   endtask

   // Enter with the main DUT in FETCH; leaves it in EXEC with opcode applied
   task automatic fetch(input logic [6:0] op, input int waits, input string tag);
      for (int i = 0; i < waits; i++) begin
         mem_ready = 1'b0;
         chk({tag, " fetch wait"}, F_WAIT);
         step();
      end
      mem_ready = 1'b1;
      chk({tag, " fetch ready"}, F_RDY);
      step();
      mem_ready = 1'b0;
      opcode = op;
      chk({tag, " decode"}, ZERO);
      step();
   endtask

   initial begin
      rst_n = 1'b0; rst_n2 = 1'b0;
      mem_ready = 1'b0; mem_ready2 = 1'b0;
      opcode = 7'd0; opcode2 = 7'd0; branch_taken = 1'b0;
      repeat (2) step();
      chk("reset", ZERO);

      rst_n = 1'b1;
      chk("idle", ZERO);
      step();
      fetch(OP_R, 1, "r");
      chk("r exec", X_R);            step();
      chk("r wb", WB_A);             step();

      fetch(OP_LOAD, 0, "load");
      chk("load exec", X_LDST);      step();
      for (int i = 0; i < 3; i++) begin
         chk("load mem wait", M_LOAD);
         step();
      end
      mem_ready = 1'b1;
      chk("load mem ready", M_LOAD); step();
      mem_ready = 1'b0;
      chk("load wb", WB_L);          step();

      fetch(OP_STORE, 0, "store");
      chk("store exec", X_LDST);     step();
      chk("store mem wait", M_ST_W); step();
      mem_ready = 1'b1;
      chk("store mem ready", M_ST_R); step();
      mem_ready = 1'b0;

      fetch(OP_BRANCH, 0, "branch");
      branch_taken = 1'b1;
      chk("branch taken", X_BR_T);
      branch_taken = 1'b0;
      chk("branch not taken", X_BR_N);
      step();

      fetch(OP_JAL, 0, "jal");
      chk("jal exec", X_JAL);        step();
      fetch(OP_JALR, 0, "jalr");
      chk("jalr exec", X_JALR);      step();
      fetch(OP_AUIPC, 0, "auipc");
      chk("auipc exec", X_AUIPC);    step();
      chk("auipc wb", WB_A);         step();
      fetch(OP_LUI, 0, "lui");
      chk("lui exec", X_LUI);        step();
      chk("lui wb", WB_A);           step();
      fetch(OP_IALU, 0, "ialu");
      chk("ialu exec", X_IALU);      step();
      chk("ialu wb", WB_A);          step();

      fetch(OP_R, 3, "ready at limit");
      chk("limit exec", X_R);        step();
      chk("limit wb", WB_A);         step();

      for (int i = 0; i < 4; i++) begin
         chk("timeout wait", F_WAIT);
         step();
      end
      chk("bus error trap", T_BUS);
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         step();
         chk("bus error hold", T_BUS);
      end
      mem_ready = 1'b0;

      rst_n = 1'b0;
      chk("async reset clears flags", ZERO);
      step();
      rst_n = 1'b1;
      mem_ready = 1'b1;
      chk("ready ignored in idle", ZERO);
      step();
      fetch(OP_LOAD, 0, "rst load");
      chk("rst load exec", X_LDST);  step();
      chk("rst load mem", M_LOAD);   step();
      chk("rst load mem 2", M_LOAD);
      rst_n = 1'b0;
      chk("reset mid mem", ZERO);
      step();
      rst_n = 1'b1;
      chk("restart idle", ZERO);     step();
      chk("restart fetch", F_WAIT);

      rst_n2 = 1'b1;
      chk("nj idle", ZERO, 1'b1);    step();
      mem_ready2 = 1'b1;
      chk("nj fetch ready", F_RDY, 1'b1); step();
      mem_ready2 = 1'b0;
      opcode2 = OP_JALR;
      chk("nj decode", ZERO, 1'b1);  step();
      for (int i = 0; i < 20; i++) begin
         mem_ready2 = i[0];
         chk("nj illegal trap", T_ILL, 1'b1);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
